// File: rtl/tile_core_scheduler.sv
// tile_core_scheduler: buffers tile descriptors from frame_tiler in a small
// FIFO and dispatches them round-robin to free compute cores, tracking per-core
// busy state and pulsing done once the frame has fully drained.
// Optional build macro: SCHED_PERF_CNT_EN enables the stall_cycles counter;
// without it stall_cycles is tied to zero.
module tile_core_scheduler #(
  parameter int NUM_CORES = 2,
  parameter int WIDTH     = 16,
  parameter int QDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 tile_valid,
  output logic                 tile_ready,
  input  logic [WIDTH-1:0]     tile_row_idx,
  input  logic [WIDTH-1:0]     tile_col_idx,
  input  logic [WIDTH-1:0]     tile_rows,
  input  logic [WIDTH-1:0]     tile_cols,
  input  logic                 tiler_done,
  output logic [NUM_CORES-1:0] core_start,
  output logic [WIDTH-1:0]     disp_row_idx,
  output logic [WIDTH-1:0]     disp_col_idx,
  output logic [WIDTH-1:0]     disp_rows,
  output logic [WIDTH-1:0]     disp_cols,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [NUM_CORES-1:0] core_busy,
  output logic [WIDTH-1:0]     tiles_dispatched,
  output logic [WIDTH-1:0]     stall_cycles,
  output logic                 err,
  output logic                 busy,
  output logic                 done
);

  localparam int AW  = $clog2(QDEPTH);
  localparam int RRW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int DW  = 4 * WIDTH;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        mem_q [QDEPTH];
  logic [DW-1:0]        mem_d [QDEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [RRW-1:0]       rr_q, rr_d;
  logic                 tdone_q, tdone_d;
  logic [NUM_CORES-1:0] core_busy_q, core_busy_d;
  logic [WIDTH-1:0]     tiles_q, tiles_d;
  logic                 err_q, err_d;
  logic [DW-1:0]        disp_q, disp_d;

  logic                 active, fifo_empty, fifo_full, start_acc;
  logic                 push, dispatch, found;
  logic [NUM_CORES-1:0] eligible, grant;
  logic [RRW-1:0]       grant_idx;
  logic [DW-1:0]        head, disp_bus;

  assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign start_acc  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign tile_ready = (state_q == S_RUN) && !fifo_full;
  assign push       = tile_valid && tile_ready;
  // Registered busy only: a core finishing this cycle is still ineligible.
  assign eligible   = ~core_busy_q;
  assign head       = mem_q[rd_ptr_q];
  assign dispatch   = active && !fifo_empty && (eligible != '0);

  // Round-robin pick: first eligible core at or above rr, else lowest eligible.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (!found && eligible[k] && (k >= 32'(rr_q))) begin
        found     = 1'b1;
        grant_idx = RRW'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (!found && eligible[k]) begin
        found     = 1'b1;
        grant_idx = RRW'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      grant[k] = dispatch && (grant_idx == RRW'(k));
    end
  end

  // Descriptor FIFO: write on accept, read on dispatch, occupancy tracking.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {tile_row_idx, tile_col_idx, tile_rows, tile_cols};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (dispatch) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, dispatch})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Frame FSM, busy tracking, round-robin pointer, counters and error flag.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    tdone_d     = tdone_q;
    core_busy_d = (core_busy_q & ~core_done) | grant;
    tiles_d     = tiles_q;
    err_d       = err_q;
    disp_d      = disp_q;

    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (tdone_q) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty && (core_busy_q == '0)) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (active) begin
      tdone_d = tdone_q | tiler_done;
    end

    if (dispatch) begin
      rr_d    = (grant_idx == RRW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      tiles_d = tiles_q + 1'b1;
      disp_d  = head;
    end

    // In IDLE, stray completions are leftovers of a reset frame and are ignored.
    if ((state_q != S_IDLE) && ((core_done & ~core_busy_q) != '0)) begin
      err_d = 1'b1;
    end
    if ((state_q == S_DRAIN) && tile_valid) begin
      err_d = 1'b1;
    end

    if (start_acc) begin
      tiles_d = '0;
      err_d   = 1'b0;
      tdone_d = 1'b0;
    end
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rr_q        <= '0;
      tdone_q     <= 1'b0;
      core_busy_q <= '0;
      tiles_q     <= '0;
      err_q       <= 1'b0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rr_q        <= rr_d;
      tdone_q     <= tdone_d;
      core_busy_q <= core_busy_d;
      tiles_q     <= tiles_d;
      err_q       <= err_d;
      disp_q      <= disp_d;
    end
  end

  // Descriptor storage; contents are only read while the FIFO holds entries.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef SCHED_PERF_CNT_EN
  logic [WIDTH-1:0] stall_q, stall_d;

  // Count active cycles where work is queued but no core is free.
  always_comb begin
    stall_d = stall_q;
    if (active && !fifo_empty && (eligible == '0)) begin
      stall_d = stall_q + 1'b1;
    end
    if (start_acc) begin
      stall_d = '0;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign disp_bus         = dispatch ? head : disp_q;
  assign disp_row_idx     = disp_bus[4*WIDTH-1:3*WIDTH];
  assign disp_col_idx     = disp_bus[3*WIDTH-1:2*WIDTH];
  assign disp_rows        = disp_bus[2*WIDTH-1:WIDTH];
  assign disp_cols        = disp_bus[WIDTH-1:0];
  assign core_start       = grant;
  assign core_busy        = core_busy_q;
  assign tiles_dispatched = tiles_q;
  assign err              = err_q;
  assign busy             = active;
  assign done             = (state_q == S_DONE);

endmodule
